// File: rtl/decode_issue_stage.sv
// Decode-to-execute pipeline register with a load-use issue interlock.
// Holds one uop under mem_stall, drops it on redirect, and counts stalls and issues.
`timescale 1ns/1ps

module decode_issue_stage #(
  parameter int UOP_W = 256,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [UOP_W-1:0] dec_uop,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_src1_is_reg,
  input  logic             dec_src2_is_reg,
  input  logic [4:0]       dec_rd,
  input  logic             dec_need_to_wb,
  input  logic             dec_is_load,
  output logic             exu_valid,
  input  logic             exu_ready,
  output logic [UOP_W-1:0] exu_uop,
  output logic [4:0]       exu_rd,
  output logic             exu_need_to_wb,
  output logic             exu_is_load,
  input  logic             mem_stall,
  input  logic             redirect_valid,
  input  logic             writeback_valid,
  input  logic [4:0]       writeback_rd,
  output logic             ld_pending,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  logic [4:0] ld_rd;
  logic       exu_load_wb;
  logic       hz1;
  logic       hz2;
  logic       hz_struct;
  logic       hazard;
  logic       in_fire;
  logic       out_fire;
  logic       ld_set;
  logic       ld_clear;

  // A source register matches if its value is still owed by a load, either
  // sitting in the output register or already issued and awaiting writeback.
  function automatic logic load_owes(input logic [4:0] r);
    return (exu_load_wb && (exu_rd == r)) || (ld_pending && (ld_rd == r));
  endfunction

  always_comb begin
    exu_load_wb = exu_valid & exu_is_load & exu_need_to_wb;
    hz1         = dec_src1_is_reg & (dec_rs1 != 5'd0) & load_owes(dec_rs1);
    hz2         = dec_src2_is_reg & (dec_rs2 != 5'd0) & load_owes(dec_rs2);
    hz_struct   = dec_is_load & dec_need_to_wb & (dec_rd != 5'd0) &
                  (ld_pending | exu_load_wb);
    hazard      = hz1 | hz2 | hz_struct;
    dec_ready   = reset_n & ~mem_stall & ~redirect_valid & ~hazard &
                  (~exu_valid | exu_ready);
    in_fire     = dec_valid & dec_ready;
    out_fire    = exu_valid & exu_ready & ~mem_stall;
    ld_set      = out_fire & exu_is_load & exu_need_to_wb & (exu_rd != 5'd0);
    ld_clear    = writeback_valid & (writeback_rd == ld_rd);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exu_valid      <= 1'b0;
      exu_uop        <= '0;
      exu_rd         <= 5'd0;
      exu_need_to_wb <= 1'b0;
      exu_is_load    <= 1'b0;
    end else if (redirect_valid) begin
      exu_valid <= 1'b0;
    end else if (in_fire) begin
      exu_valid      <= 1'b1;
      exu_uop        <= dec_uop;
      exu_rd         <= dec_rd;
      exu_need_to_wb <= dec_need_to_wb;
      exu_is_load    <= dec_is_load;
    end else if (out_fire) begin
      exu_valid <= 1'b0;
    end
  end

  // The tracker survives redirects: the issued load is older than the branch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ld_pending <= 1'b0;
      ld_rd      <= 5'd0;
    end else if (ld_set) begin
      ld_pending <= 1'b1;
      ld_rd      <= exu_rd;
    end else if (ld_clear) begin
      ld_pending <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (dec_valid && !dec_ready) stall_cnt <= stall_cnt + CNT_W'(1);
      if (out_fire)                issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: streaming, load-use, redirect,
// structural load hazard, mem_stall and asynchronous reset, with fixed expectations.
`timescale 1ns/1ps

module tb_decode_issue_stage;

  logic         clock;
  logic         reset_n;
  logic         dec_valid;
  logic         dec_ready;
  logic [255:0] dec_uop;
  logic [4:0]   dec_rs1;
  logic [4:0]   dec_rs2;
  logic         dec_src1_is_reg;
  logic         dec_src2_is_reg;
  logic [4:0]   dec_rd;
  logic         dec_need_to_wb;
  logic         dec_is_load;
  logic         exu_valid;
  logic         exu_ready;
  logic [255:0] exu_uop;
  logic [4:0]   exu_rd;
  logic         exu_need_to_wb;
  logic         exu_is_load;
  logic         mem_stall;
  logic         redirect_valid;
  logic         writeback_valid;
  logic [4:0]   writeback_rd;
  logic         ld_pending;
  logic [31:0]  stall_cnt;
  logic [31:0]  issue_cnt;

  int total;
  int bad;

  decode_issue_stage #(.UOP_W(256), .CNT_W(32)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_uop         (dec_uop),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_src1_is_reg (dec_src1_is_reg),
    .dec_src2_is_reg (dec_src2_is_reg),
    .dec_rd          (dec_rd),
    .dec_need_to_wb  (dec_need_to_wb),
    .dec_is_load     (dec_is_load),
    .exu_valid       (exu_valid),
    .exu_ready       (exu_ready),
    .exu_uop         (exu_uop),
    .exu_rd          (exu_rd),
    .exu_need_to_wb  (exu_need_to_wb),
    .exu_is_load     (exu_is_load),
    .mem_stall       (mem_stall),
    .redirect_valid  (redirect_valid),
    .writeback_valid (writeback_valid),
    .writeback_rd    (writeback_rd),
    .ld_pending      (ld_pending),
    .stall_cnt       (stall_cnt),
    .issue_cnt       (issue_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [255:0] uop,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic s1, input logic s2, input logic [4:0] rd,
                                input logic wb, input logic ld);
    dec_valid       = v;
    dec_uop         = uop;
    dec_rs1         = rs1;
    dec_rs2         = rs2;
    dec_src1_is_reg = s1;
    dec_src2_is_reg = s2;
    dec_rd          = rd;
    dec_need_to_wb  = wb;
    dec_is_load     = ld;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset_n         = 1'b0;
    exu_ready       = 1'b0;
    mem_stall       = 1'b0;
    redirect_valid  = 1'b0;
    writeback_valid = 1'b0;
    writeback_rd    = 5'd0;
    apply_stimulus(1'b0, 256'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    #1;
    check_output("rst_exu_valid", 256'(exu_valid), 256'(0));
    check_output("rst_dec_ready", 256'(dec_ready), 256'(0));
    check_output("rst_ld_pending", 256'(ld_pending), 256'(0));
    check_output("rst_issue_cnt", 256'(issue_cnt), 256'(0));
    check_output("rst_stall_cnt", 256'(stall_cnt), 256'(0));
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    #1;
    check_output("idle_dec_ready", 256'(dec_ready), 256'(1));

    $display("[TB] streaming");
    exu_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1'b1, 256'(k + 100), 5'd0, 5'd0, 1'b0, 1'b0, 5'(k + 1), 1'b1, 1'b0);
      #1;
      check_output("stream_dec_ready", 256'(dec_ready), 256'(1));
      next_cycle();
      check_output("stream_exu_valid", 256'(exu_valid), 256'(1));
      check_output("stream_exu_uop", exu_uop, 256'(k + 100));
    end
    check_output("stream_issue_7", 256'(issue_cnt), 256'(7));
    check_output("stream_stall_0", 256'(stall_cnt), 256'(0));
    apply_stimulus(1'b0, 256'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    check_output("stream_drain_valid", 256'(exu_valid), 256'(0));
    check_output("stream_issue_8", 256'(issue_cnt), 256'(8));

    $display("[TB] load-use");
    apply_stimulus(1'b1, 256'h200, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    #1;
    check_output("lu_load_ready", 256'(dec_ready), 256'(1));
    next_cycle();
    check_output("lu_exu_is_load", 256'(exu_is_load), 256'(1));
    check_output("lu_exu_rd", 256'(exu_rd), 256'(5));
    apply_stimulus(1'b1, 256'h201, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    #1;
    check_output("lu_ready_exu_hit", 256'(dec_ready), 256'(0));
    next_cycle();
    check_output("lu_ld_pending_set", 256'(ld_pending), 256'(1));
    check_output("lu_exu_bubble", 256'(exu_valid), 256'(0));
    check_output("lu_issue_9", 256'(issue_cnt), 256'(9));
    check_output("lu_stall_1", 256'(stall_cnt), 256'(1));
    #1;
    check_output("lu_ready_c", 256'(dec_ready), 256'(0));
    next_cycle();
    check_output("lu_stall_2", 256'(stall_cnt), 256'(2));
    #1;
    check_output("lu_ready_d", 256'(dec_ready), 256'(0));
    next_cycle();
    check_output("lu_stall_3", 256'(stall_cnt), 256'(3));
    writeback_valid = 1'b1;
    writeback_rd    = 5'd5;
    #1;
    check_output("lu_ready_wb_cycle", 256'(dec_ready), 256'(0));
    check_output("lu_pending_wb_cycle", 256'(ld_pending), 256'(1));
    next_cycle();
    writeback_valid = 1'b0;
    check_output("lu_ld_pending_clr", 256'(ld_pending), 256'(0));
    check_output("lu_stall_4", 256'(stall_cnt), 256'(4));
    #1;
    check_output("lu_ready_after_wb", 256'(dec_ready), 256'(1));
    next_cycle();
    check_output("lu_add_valid", 256'(exu_valid), 256'(1));
    check_output("lu_add_rd", 256'(exu_rd), 256'(6));
    check_output("lu_add_uop", exu_uop, 256'h201);
    apply_stimulus(1'b0, 256'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    check_output("lu_issue_10", 256'(issue_cnt), 256'(10));

    $display("[TB] redirect");
    apply_stimulus(1'b1, 256'h300, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, 256'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    check_output("rd_ld_pending_7", 256'(ld_pending), 256'(1));
    check_output("rd_issue_11", 256'(issue_cnt), 256'(11));
    apply_stimulus(1'b1, 256'h80000010, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
    exu_ready = 1'b0;
    #1;
    check_output("rd_accept_ready", 256'(dec_ready), 256'(1));
    next_cycle();
    check_output("rd_hold_valid", 256'(exu_valid), 256'(1));
    check_output("rd_hold_pc", exu_uop, 256'h80000010);
    apply_stimulus(1'b0, 256'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    redirect_valid = 1'b1;
    #1;
    check_output("rd_pulse_ready", 256'(dec_ready), 256'(0));
    next_cycle();
    redirect_valid = 1'b0;
    check_output("rd_killed", 256'(exu_valid), 256'(0));
    check_output("rd_tracker_kept", 256'(ld_pending), 256'(1));
    check_output("rd_issue_held", 256'(issue_cnt), 256'(11));

    $display("[TB] structural and rs0");
    exu_ready = 1'b1;
    apply_stimulus(1'b1, 256'h400, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1);
    writeback_valid = 1'b1;
    writeback_rd    = 5'd8;
    #1;
    check_output("st_ready_blocked", 256'(dec_ready), 256'(0));
    next_cycle();
    writeback_rd = 5'd7;
    check_output("st_other_wb_keeps", 256'(ld_pending), 256'(1));
    check_output("st_stall_5", 256'(stall_cnt), 256'(5));
    #1;
    check_output("st_ready_wb_cycle", 256'(dec_ready), 256'(0));
    next_cycle();
    writeback_valid = 1'b0;
    check_output("st_pending_clr", 256'(ld_pending), 256'(0));
    check_output("st_stall_6", 256'(stall_cnt), 256'(6));
    #1;
    check_output("st_ready_free", 256'(dec_ready), 256'(1));
    next_cycle();
    check_output("st_load9_rd", 256'(exu_rd), 256'(9));
    check_output("st_load9_is_load", 256'(exu_is_load), 256'(1));
    apply_stimulus(1'b1, 256'h401, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    #1;
    check_output("st_rd0_load_ready", 256'(dec_ready), 256'(1));
    next_cycle();
    check_output("st_pending_rd9", 256'(ld_pending), 256'(1));
    check_output("st_issue_12", 256'(issue_cnt), 256'(12));
    check_output("st_rd0_in_exu", 256'(exu_rd), 256'(0));
    apply_stimulus(1'b1, 256'h402, 5'd0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    check_output("st_rs0_ready", 256'(dec_ready), 256'(1));
    next_cycle();
    check_output("st_issue_13", 256'(issue_cnt), 256'(13));
    check_output("st_pending_still", 256'(ld_pending), 256'(1));
    check_output("st_reader_uop", exu_uop, 256'h402);
    apply_stimulus(1'b1, 256'h403, 5'd0, 5'd9, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0);
    #1;
    check_output("st_hz2_ready", 256'(dec_ready), 256'(0));
    next_cycle();
    check_output("st_issue_14", 256'(issue_cnt), 256'(14));
    check_output("st_stall_7", 256'(stall_cnt), 256'(7));
    check_output("st_hz2_bubble", 256'(exu_valid), 256'(0));
    apply_stimulus(1'b0, 256'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    writeback_valid = 1'b1;
    writeback_rd    = 5'd9;
    next_cycle();
    writeback_valid = 1'b0;
    check_output("st_pending_rd9_clr", 256'(ld_pending), 256'(0));

    $display("[TB] mem_stall");
    apply_stimulus(1'b1, 256'hABC, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
    next_cycle();
    check_output("ms_loaded", exu_uop, 256'hABC);
    apply_stimulus(1'b1, 256'hDEF, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b1, 1'b0);
    mem_stall = 1'b1;
    #1;
    check_output("ms_ready_low", 256'(dec_ready), 256'(0));
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_output("ms_valid_held", 256'(exu_valid), 256'(1));
      check_output("ms_uop_stable", exu_uop, 256'hABC);
      check_output("ms_issue_held", 256'(issue_cnt), 256'(14));
      check_output("ms_stall_inc", 256'(stall_cnt), 256'(8 + i));
    end
    mem_stall = 1'b0;
    #1;
    check_output("ms_ready_back", 256'(dec_ready), 256'(1));
    next_cycle();
    check_output("ms_issue_15", 256'(issue_cnt), 256'(15));
    check_output("ms_next_uop", exu_uop, 256'hDEF);
    apply_stimulus(1'b0, 256'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    check_output("ms_issue_16", 256'(issue_cnt), 256'(16));
    check_output("ms_stall_10", 256'(stall_cnt), 256'(10));

    $display("[TB] reset mid-operation");
    apply_stimulus(1'b1, 256'h500, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1);
    next_cycle();
    apply_stimulus(1'b1, 256'h501, 5'd0, 5'd0, 1'b0, 1'b0, 5'd14, 1'b1, 1'b0);
    #1;
    check_output("mr_ready", 256'(dec_ready), 256'(1));
    next_cycle();
    check_output("mr_pending", 256'(ld_pending), 256'(1));
    check_output("mr_valid", 256'(exu_valid), 256'(1));
    check_output("mr_issue_17", 256'(issue_cnt), 256'(17));
    apply_stimulus(1'b0, 256'h0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    exu_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_output("mr_exu_valid", 256'(exu_valid), 256'(0));
    check_output("mr_ld_pending", 256'(ld_pending), 256'(0));
    check_output("mr_exu_uop", exu_uop, 256'h0);
    check_output("mr_exu_rd", 256'(exu_rd), 256'(0));
    check_output("mr_exu_wb", 256'(exu_need_to_wb), 256'(0));
    check_output("mr_issue_cnt", 256'(issue_cnt), 256'(0));
    check_output("mr_stall_cnt", 256'(stall_cnt), 256'(0));
    check_output("mr_dec_ready", 256'(dec_ready), 256'(0));
    #10;
    reset_n = 1'b1;
    #10;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
